muldiv_iter: RTL and testbench
==============================

# muldiv_iter

Iterative multiply/divide unit for the RV32M/RV64M extension, parametrised in `Width`. It sits beside the single-cycle ALU in the execute stage. It accepts one operation through a valid/ready handshake and computes one result bit per cycle using shift-add multiplication and restoring division. The result is returned through a second valid/ready handshake, and a flush input can abandon the operation in flight.

## Interface
- `Width`, 32: operand and result width. Must be a power of two, at least 8.
- `clk` input 1: clock. All state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `flush` input 1: abandons any in-flight or completed-but-unconsumed operation.
- `in_valid` input 1: request valid.
- `in_ready` output 1: unit can accept a request.
- `op` input `rvcpu::muldiv_op_t`: operation to perform.
- `a` input `Width`: rs1 operand.
- `b` input `Width`: rs2 operand.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `res` output `Width`: result.

## Operation
- FSM states: `IDLE`, `CALC`, `DONE`.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`, latch `op`, the operands and the sign information, then go to `CALC`.
  - Special cases go directly to `DONE` instead (see below).
- **Operand preparation**
  - Signed operands are converted to magnitude:
    - `mulh`: both operands.
    - `mulhsu`: `a` only.
    - `div`, `rem`: both operands.
  - Result sign:
    - mul*: XOR of the operand signs.
    - quotient: XOR of the operand signs.
    - remainder: sign of `a`.
- **Multiply** (`mul`, `mulh`, `mulhsu`, `mulhu`)
  - 2·`Width` accumulator, one shift-add per cycle, `Width` iterations.
  - The product is negated when the result sign is set.
  - `mul` returns the low `Width` bits; the three high variants return the high `Width` bits.
- **Divide** (`div`, `divu`, `rem`, `remu`)
  - Restoring division, `Width` iterations; each iteration produces one quotient bit.
  - The quotient or remainder is negated according to its sign rule.
- **Special cases** (resolved in IDLE; go to `DONE` next cycle, no `CALC`)
  - `b`==0:
    - `div`/`divu` → all ones.
    - `rem`/`remu` → `a`.
  - Signed overflow (`a`=most negative, `b`=−1):
    - `div` → `a`.
    - `rem` → 0.
- **CALC**
  - An iteration counter of `$clog2(Width)+1` bits counts down from `Width-1`.
  - When the counter reaches 0: apply the final sign correction, register `res`, go to `DONE`.
- **DONE**
  - `out_valid`=1 and `res` held stable.
  - On `out_ready`, go to `IDLE`.
- **Flush**: forces `IDLE` from any state. `out_valid` drops the next cycle, and no result is ever presented for the flushed operation.
- **Reset**: state=`IDLE`, `out_valid`=0, `res`=0, counter=0. `in_ready`=1 from the first cycle after `rst` deasserts.

## Timing
- A request is accepted on the edge where `in_valid && in_ready`.
- **Normal latency**: `out_valid` rises `Width+1` cycles after the accepting edge (33 for `Width`=32).
- **Special-case latency**: `out_valid` rises 1 cycle after the accepting edge.
- `in_ready` depends only on state. There is no combinational path from `in_valid` to `in_ready`.
- `out_valid` and `res` are registered and stay stable until the consuming handshake.
- No back-to-back overlap: the first cycle a new request can be accepted is the cycle after `out_valid && out_ready`.
- Changes to `a`, `b` or `op` after acceptance have no effect.
- `flush` has priority over a simultaneous `in_valid` in `IDLE`: the request is not accepted.
- `flush` has priority over a simultaneous `out_ready`: the result is dropped.
- `rst` has priority over everything, including `flush`.

## Structure
- Package `rvcpu` gains `muldiv_op_t`, a 3-bit enum encoded as funct3:
  - `md_mul`=0, `md_mulh`=1, `md_mulhsu`=2, `md_mulhu`=3
  - `md_div`=4, `md_divu`=5, `md_rem`=6, `md_remu`=7
- Package `rvcpu` also gains the state enum `muldiv_state_t`.
- Helper functions live in the package: `is_div(op)`, `is_signed_a(op)`, `is_signed_b(op)`.
- No sub-module. The shared shift register, adder/subtractor and counter stay in one module, because multiply and divide share the 2·`Width` register and a `Width+1` adder.

## Test plan
- `mul`, `a`=7, `b`=−3 (0xFFFFFFFD) → `res`=0xFFFFFFEB (−21); `out_valid` rises exactly 33 cycles after acceptance.
- `mulhu`, `a`=`b`=0xFFFFFFFF → `res`=0xFFFFFFFE; `mulh` with the same operands → 0x00000000; `mulhsu` with the same operands → 0xFFFFFFFF.
- `div`, `a`=−7, `b`=2 → `res`=0xFFFFFFFD (−3); `rem` with the same operands → 0xFFFFFFFF (−1); `divu` 100/7 → 14; `remu` 100/7 → 2.
- Divide-by-zero:
  - `divu` 5/0 → 0xFFFFFFFF.
  - `rem` 5/0 → 5.
  - `div` 0x80000000/0xFFFFFFFF → 0x80000000.
  - `rem` 0x80000000/0xFFFFFFFF → 0.
  - All four present `out_valid` 1 cycle after acceptance.
- Back-pressure: hold `out_ready`=0 for 10 cycles after `out_valid` rises → `res` stable and `in_ready`=0 throughout; a new request is accepted only the cycle after the handshake.
- Flush and reset:
  - `flush` at CALC cycle 5 → `IDLE` next cycle and no `out_valid`; the following request returns the correct result.
  - `rst` asserted mid-CALC → `out_valid`=0, `res`=0, `in_ready`=1 after release.

Source files
------------

// File: rtl/muldiv_iter_pkg.sv
// Shared CPU types for the iterative multiply/divide unit: op encoding (funct3),
// FSM states and operand-sign helpers.
package rvcpu;

    typedef enum logic [2:0] {
        md_mul    = 3'd0,
        md_mulh   = 3'd1,
        md_mulhsu = 3'd2,
        md_mulhu  = 3'd3,
        md_div    = 3'd4,
        md_divu   = 3'd5,
        md_rem    = 3'd6,
        md_remu   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    function automatic logic is_div(muldiv_op_t op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(muldiv_op_t op);
        return op inside {md_mulh, md_mulhsu, md_div, md_rem};
    endfunction

    function automatic logic is_signed_b(muldiv_op_t op);
        return op inside {md_mulh, md_div, md_rem};
    endfunction

endpackage

// File: rtl/muldiv_iter_if.sv
// Request/response handshake bundle between the execute stage and muldiv_iter.
interface muldiv_iter_if #(
    parameter int unsigned Width = 32
) ();
    import rvcpu::*;

    logic             in_valid;
    logic             in_ready;
    muldiv_op_t       op;
    logic [Width-1:0] a;
    logic [Width-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [Width-1:0] res;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, res
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, res
    );

endinterface

// File: rtl/muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide: shift-add multiply and restoring divide
// sharing one 2*Width accumulator and one Width+1 adder, one result bit per cycle.
module muldiv_iter
    import rvcpu::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_flush,
    muldiv_iter_if.slave bus
);

    localparam int unsigned CntW = $clog2(Width) + 1;

    muldiv_state_t      r_state, w_state_nxt;
    muldiv_op_t         r_op, w_op_nxt;
    logic [2*Width-1:0] r_acc, w_acc_nxt;
    logic [Width-1:0]   r_b, w_b_nxt;
    logic               r_neg, w_neg_nxt;
    logic [CntW-1:0]    r_cnt, w_cnt_nxt;
    logic [Width-1:0]   r_res, w_res_nxt;

    logic [Width-1:0]   w_min;
    logic               w_sa, w_sb, w_neg_in;
    logic [Width-1:0]   w_a_mag, w_b_mag;
    logic               w_div_zero, w_ovf, w_special;
    logic [Width-1:0]   w_special_res;
    logic [Width:0]     w_lhs, w_sum;
    logic               w_qbit;
    logic [2*Width-1:0] w_acc_step, w_prod;
    logic [Width-1:0]   w_quo, w_rem, w_final;

    assign w_min         = {1'b1, {(Width-1){1'b0}}};
    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.res       = r_res;

    always_comb begin : operand_prep
        w_sa       = bus.a[Width-1] & is_signed_a(bus.op);
        w_sb       = bus.b[Width-1] & is_signed_b(bus.op);
        w_a_mag    = w_sa ? -bus.a : bus.a;
        w_b_mag    = w_sb ? -bus.b : bus.b;
        // Remainder takes the dividend's sign; everything else the XOR of both.
        w_neg_in   = (bus.op inside {md_rem, md_remu}) ? w_sa : (w_sa ^ w_sb);
        w_div_zero = is_div(bus.op) && (bus.b == '0);
        w_ovf      = (bus.op inside {md_div, md_rem}) && (bus.a == w_min) && (bus.b == '1);
        w_special  = w_div_zero || w_ovf;
        if (w_div_zero) begin
            w_special_res = (bus.op inside {md_div, md_divu}) ? '1 : bus.a;
        end else begin
            w_special_res = (bus.op == md_div) ? bus.a : '0;
        end
    end

    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, quotient}.
    always_comb begin : iterate
        w_lhs = is_div(r_op) ? r_acc[2*Width-1:Width-1] : {1'b0, r_acc[2*Width-1:Width]};
        w_sum = is_div(r_op) ? (w_lhs - {1'b0, r_b}) : (w_lhs + {1'b0, r_b});
        if (is_div(r_op)) begin
            w_qbit     = ~w_sum[Width];
            w_acc_step = {(w_qbit ? w_sum[Width-1:0] : w_lhs[Width-1:0]),
                          r_acc[Width-2:0], w_qbit};
        end else begin
            w_qbit     = 1'b0;
            w_acc_step = r_acc[0] ? {w_sum, r_acc[Width-1:1]} : {1'b0, r_acc[2*Width-1:1]};
        end
    end

    always_comb begin : finalize
        w_prod = r_neg ? -w_acc_step : w_acc_step;
        w_quo  = r_neg ? -w_acc_step[Width-1:0] : w_acc_step[Width-1:0];
        w_rem  = r_neg ? -w_acc_step[2*Width-1:Width] : w_acc_step[2*Width-1:Width];
        case (r_op)
            md_mul:                      w_final = w_prod[Width-1:0];
            md_mulh, md_mulhsu, md_mulhu: w_final = w_prod[2*Width-1:Width];
            md_div, md_divu:             w_final = w_quo;
            default:                     w_final = w_rem;
        endcase
    end

    always_comb begin : next_state
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_acc_nxt   = r_acc;
        w_b_nxt     = r_b;
        w_neg_nxt   = r_neg;
        w_cnt_nxt   = r_cnt;
        w_res_nxt   = r_res;
        case (r_state)
            IDLE: begin
                if (bus.in_valid && !i_flush) begin
                    w_op_nxt  = bus.op;
                    w_b_nxt   = w_b_mag;
                    w_neg_nxt = w_neg_in;
                    w_acc_nxt = {{Width{1'b0}}, w_a_mag};
                    w_cnt_nxt = CntW'(Width - 1);
                    if (w_special) begin
                        w_res_nxt   = w_special_res;
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                w_acc_nxt = w_acc_step;
                if (r_cnt == '0) begin
                    w_res_nxt   = w_final;
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt - CntW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (i_flush) w_state_nxt = IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op  <= md_mul;
            r_acc <= '0;
            r_b   <= '0;
            r_neg <= 1'b0;
            r_cnt <= '0;
            r_res <= '0;
        end else begin
            r_op  <= w_op_nxt;
            r_acc <= w_acc_nxt;
            r_b   <= w_b_nxt;
            r_neg <= w_neg_nxt;
            r_cnt <= w_cnt_nxt;
            r_res <= w_res_nxt;
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: directed vectors, randomized ops against a
// 64-bit arithmetic reference, back-pressure, flush and mid-operation reset.
module tb_muldiv_iter;
    import rvcpu::*;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;

    muldiv_iter_if #(.Width(W)) bus ();

    muldiv_iter #(.Width(W)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        muldiv_op_t  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    function automatic logic [31:0] ref_model(muldiv_op_t op, logic [31:0] a, logic [31:0] b);
        logic signed [63:0] sa, sb, ub, ps;
        logic [63:0]        pu;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ub  = {32'd0, b};
        pu  = {32'd0, a} * {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            md_mul:    return pu[31:0];
            md_mulh:   begin ps = sa * sb; return ps[63:32]; end
            md_mulhsu: begin ps = sa * ub; return ps[63:32]; end
            md_mulhu:  return pu[63:32];
            md_div: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                ps = sa / sb;
                return ps[31:0];
            end
            md_divu:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            md_rem: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                ps = sa % sb;
                return ps[31:0];
            end
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(muldiv_op_t op, logic [31:0] a, logic [31:0] b);
        bit special;
        special = ((op inside {md_div, md_divu, md_rem, md_remu}) && b == 0) ||
                  ((op inside {md_div, md_rem}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return special ? 1 : W + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one request, scramble inputs after acceptance, measure latency, consume.
    task automatic run_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output int lat);
        int guard;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        bus.in_valid = 1'b1;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        bus.op = muldiv_op_t'($urandom_range(0, 7));
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            if (bus.out_valid === 1'b1) begin
                lat = i;
                break;
            end
            @(posedge clk); #1;
        end
        r = bus.res;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        checks++;
        if (bus.res !== 32'd0) begin
            errors++; $display("FAIL reset_res: got %h expected 00000000", bus.res);
        end
    endtask

    task automatic test_directed();
        vec_t        v[12];
        logic [31:0] r;
        int          lat;
        v[0]  = '{md_mul,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        v[1]  = '{md_mulhu,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        v[2]  = '{md_mulh,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33};
        v[3]  = '{md_mulhsu, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        v[4]  = '{md_div,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        v[5]  = '{md_rem,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        v[6]  = '{md_divu,   32'd100,        32'd7,         32'd14,        33};
        v[7]  = '{md_remu,   32'd100,        32'd7,         32'd2,         33};
        v[8]  = '{md_divu,   32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        v[9]  = '{md_rem,    32'd5,          32'd0,         32'd5,         1};
        v[10] = '{md_div,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        v[11] = '{md_rem,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
        for (int i = 0; i < 12; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, r, lat);
            checks++;
            if (r !== v[i].exp) begin
                errors++;
                $display("FAIL directed_res[%0d] %s: got %h expected %h", i, v[i].op.name(),
                         r, v[i].exp);
            end
            checks++;
            if (lat != v[i].lat) begin
                errors++;
                $display("FAIL directed_lat[%0d] %s: got %0d expected %0d", i, v[i].op.name(),
                         lat, v[i].lat);
            end
        end
    endtask

    task automatic test_random();
        muldiv_op_t  op;
        logic [31:0] a, b, r;
        int          lat;
        for (int i = 0; i < 150; i++) begin
            op = muldiv_op_t'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run_op(op, a, b, r, lat);
            checks++;
            if (r !== ref_model(op, a, b)) begin
                errors++;
                $display("FAIL random_res %s a=%h b=%h: got %h expected %h", op.name(), a, b,
                         r, ref_model(op, a, b));
            end
            checks++;
            if (lat != ref_latency(op, a, b)) begin
                errors++;
                $display("FAIL random_lat %s a=%h b=%h: got %0d expected %0d", op.name(), a, b,
                         lat, ref_latency(op, a, b));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, r0;
        int          guard;
        a = $urandom;
        b = $urandom;
        bus.op = md_mulhu; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        guard = 0;
        while (bus.out_valid !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_timeout: got out_valid=%b expected 1", bus.out_valid);
            return;
        end
        r0 = bus.res;
        checks++;
        if (r0 !== ref_model(md_mulhu, a, b)) begin
            errors++; $display("FAIL bp_res: got %h expected %h", r0, ref_model(md_mulhu, a, b));
        end
        bus.op = md_divu; bus.a = 32'd1000; bus.b = 32'd3; bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.res !== r0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got res=%h in_ready=%b out_valid=%b expected %h 0 1",
                         i, bus.res, bus.in_ready, bus.out_valid, r0);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_handshake: got in_ready=%b out_valid=%b expected 1 0",
                     bus.in_ready, bus.out_valid);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_accept_next: got in_ready=%b expected 0", bus.in_ready);
        end
        guard = 0;
        while (bus.out_valid !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.res !== 32'd333) begin
            errors++;
            $display("FAIL bp_second_res: got valid=%b res=%h expected 1 0000014d",
                     bus.out_valid, bus.res);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic [31:0] a, b, r;
        int          lat;
        int          seen;
        bus.op = md_mulhu; bus.a = $urandom; bus.b = $urandom; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_calc: got in_ready=%b out_valid=%b expected 1 0",
                     bus.in_ready, bus.out_valid);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL flush_no_result: got %0d valid cycles expected 0", seen);
        end
        // Flush beats a simultaneous request in IDLE.
        bus.op = md_divu; bus.a = 32'd9; bus.b = 32'd0; bus.in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_reject: got in_ready=%b out_valid=%b expected 1 0",
                     bus.in_ready, bus.out_valid);
        end
        // Flush beats a simultaneous consume in DONE.
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL flush_done_setup: got out_valid=%b expected 1", bus.out_valid);
        end
        bus.out_ready = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0; flush = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_done: got out_valid=%b in_ready=%b expected 0 1",
                     bus.out_valid, bus.in_ready);
        end
        a = pick();
        b = pick();
        run_op(md_div, a, b, r, lat);
        checks++;
        if (r !== ref_model(md_div, a, b) || lat != ref_latency(md_div, a, b)) begin
            errors++;
            $display("FAIL flush_after: got res=%h lat=%0d expected %h %0d", r, lat,
                     ref_model(md_div, a, b), ref_latency(md_div, a, b));
        end
    endtask

    task automatic test_rst_mid();
        logic [31:0] r;
        int          lat;
        run_op(md_divu, 32'd100, 32'd7, r, lat);
        checks++;
        if (bus.res !== 32'd14) begin
            errors++; $display("FAIL rst_pre_res: got %h expected 0000000e", bus.res);
        end
        bus.op = md_mul; bus.a = $urandom; bus.b = $urandom; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.res !== 32'd0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid: got out_valid=%b res=%h in_ready=%b expected 0 00000000 1",
                     bus.out_valid, bus.res, bus.in_ready);
        end
        run_op(md_rem, 32'hFFFF_FF9C, 32'd7, r, lat);
        checks++;
        if (r !== ref_model(md_rem, 32'hFFFF_FF9C, 32'd7) || lat != W + 1) begin
            errors++;
            $display("FAIL rst_after: got res=%h lat=%0d expected %h %0d", r, lat,
                     ref_model(md_rem, 32'hFFFF_FF9C, 32'd7), W + 1);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.op = md_mul;
        bus.a = '0;
        bus.b = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
